// File: rtl/downscale_pkg.sv
// Shared encodings and helpers for the downscale_nx streaming image downscaler.
package downscale_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic MODE_DECIM = 1'b0;
    localparam logic MODE_AVG   = 1'b1;
    localparam logic FACTOR_2   = 1'b0;
    localparam logic FACTOR_4   = 1'b1;

    // Accumulator guard bits: a 4x4 block sum of full-scale pixels needs 4 more bits.
    localparam int ACC_GUARD_W = 4;

    // Phase mask inside a block (F-1): selects the low col/row bits that index a pixel in its block.
    function automatic logic [1:0] block_mask(input logic factor);
        logic [1:0] mask;
        case (factor)
            FACTOR_4: mask = 2'd3;
            FACTOR_2: mask = 2'd1;
            default:  mask = 2'd1;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/downscale_acc_line.sv
// Per-block-column vertical accumulator line: combinational read, synchronous write.
module downscale_acc_line
    import downscale_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_WIDTH = 320,
    parameter int DIM_W     = 9
) (
    input  logic                          clk_i,
    input  logic                          wr_en_i,
    input  logic [DIM_W-1:0]              wr_addr_i,
    input  logic [DATA_W+ACC_GUARD_W-1:0] wr_data_i,
    input  logic [DIM_W-1:0]              rd_addr_i,
    output logic [DATA_W+ACC_GUARD_W-1:0] rd_data_o
);

    localparam int ACC_W   = DATA_W + ACC_GUARD_W;
    localparam int ENTRIES = MAX_WIDTH / 2;
    localparam int AW      = $clog2(ENTRIES);

    logic [ACC_W-1:0] mem_q [ENTRIES];
    logic             wr_in_range_s;
    logic             rd_in_range_s;

    // Out-of-range addresses are dropped on write and read back as zero.
    assign wr_in_range_s = (wr_addr_i < DIM_W'(ENTRIES));
    assign rd_in_range_s = (rd_addr_i < DIM_W'(ENTRIES));
    assign rd_data_o     = rd_in_range_s ? mem_q[rd_addr_i[AW-1:0]] : '0;

    // Contents need no reset: the first row of every block row overwrites its entry.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && wr_in_range_s) begin
            mem_q[wr_addr_i[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/downscale_nx.sv
// downscale_nx: raster-order 2x/4x image downscaler (decimation or block average)
// with valid/ready streams and per-frame configuration latched at start.
module downscale_nx
    import downscale_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_WIDTH = 320,
    parameter int DIM_W     = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              mode,
    input  logic              factor_sel,
    input  logic [DIM_W-1:0]  img_width,
    input  logic [DIM_W-1:0]  img_height,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] pixel_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] pixel_out,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    localparam int ACC_W = DATA_W + ACC_GUARD_W;

    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic              factor_q, factor_d;
    logic [DIM_W-1:0]  width_q, width_d;
    logic [DIM_W-1:0]  height_q, height_d;
    logic [DIM_W-1:0]  col_q, col_d;
    logic [DIM_W-1:0]  row_q, row_d;
    logic [ACC_W-1:0]  hs_q, hs_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] pixel_out_q, pixel_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cfg_err_q, cfg_err_d;

    logic [1:0]        cfg_mask_s, mask_s, col_ph_s, row_ph_s;
    logic              cfg_ok_s, accept_s, col_last_s, last_pix_s;
    logic              grp_end_s, row_first_s, row_last_s;
    logic              decim_hit_s, avg_hit_s, load_s, acc_we_s;
    logic [DIM_W-1:0]  acc_addr_s;
    logic [ACC_W-1:0]  hs_total_s, acc_rd_s, acc_wr_s;
    logic [DATA_W-1:0] avg_val_s, load_val_s;

    assign cfg_mask_s = block_mask(factor_sel);
    assign cfg_ok_s   = (img_width != '0) && (img_height != '0)
                     && ((img_width[1:0] & cfg_mask_s) == 2'd0)
                     && ((img_height[1:0] & cfg_mask_s) == 2'd0)
                     && (img_width <= DIM_W'(MAX_WIDTH));

    assign in_ready   = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    assign accept_s   = in_valid && in_ready;

    assign mask_s      = block_mask(factor_q);
    assign col_ph_s    = col_q[1:0] & mask_s;
    assign row_ph_s    = row_q[1:0] & mask_s;
    assign grp_end_s   = (col_ph_s == mask_s);
    assign row_first_s = (row_ph_s == 2'd0);
    assign row_last_s  = (row_ph_s == mask_s);
    assign col_last_s  = (col_q == width_q - DIM_W'(1));
    assign last_pix_s  = col_last_s && (row_q == height_q - DIM_W'(1));

    // Averaging: hs sums the pixels of one block row, the line entry sums block rows.
    assign acc_addr_s = (factor_q == FACTOR_4) ? (col_q >> 2'd2) : (col_q >> 2'd1);
    assign hs_total_s = ((col_ph_s == 2'd0) ? '0 : hs_q) + ACC_W'(pixel_in);
    assign acc_wr_s   = (row_first_s ? '0 : acc_rd_s) + hs_total_s;
    assign acc_we_s   = accept_s && (mode_q == MODE_AVG) && grp_end_s;
    assign avg_val_s  = (factor_q == FACTOR_4) ? DATA_W'((acc_rd_s + hs_total_s) >> 3'd4)
                                               : DATA_W'((acc_rd_s + hs_total_s) >> 3'd2);

    assign decim_hit_s = (mode_q == MODE_DECIM) && row_first_s && (col_ph_s == 2'd0);
    assign avg_hit_s   = (mode_q == MODE_AVG) && row_last_s && grp_end_s;
    assign load_s      = accept_s && (decim_hit_s || avg_hit_s);
    assign load_val_s  = (mode_q == MODE_DECIM) ? pixel_in : avg_val_s;

    downscale_acc_line #(
        .DATA_W    (DATA_W),
        .MAX_WIDTH (MAX_WIDTH),
        .DIM_W     (DIM_W)
    ) u_acc_line (
        .clk_i     (clk),
        .wr_en_i   (acc_we_s),
        .wr_addr_i (acc_addr_s),
        .wr_data_i (acc_wr_s),
        .rd_addr_i (acc_addr_s),
        .rd_data_o (acc_rd_s)
    );

    // Frame sequencing: config latch, raster counters and status pulses.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        factor_d  = factor_q;
        width_d   = width_q;
        height_d  = height_q;
        col_d     = col_q;
        row_d     = row_q;
        hs_d      = hs_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && cfg_ok_s) begin
                    mode_d   = mode;
                    factor_d = factor_sel;
                    width_d  = img_width;
                    height_d = img_height;
                    col_d    = '0;
                    row_d    = '0;
                    hs_d     = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_RUN;
                end else begin
                    cfg_err_d = start;
                end
            end
            ST_RUN: begin
                if (accept_s) begin
                    hs_d = hs_total_s;
                    if (col_last_s) begin
                        col_d = '0;
                        row_d = row_q + DIM_W'(1);
                    end else begin
                        col_d = col_q + DIM_W'(1);
                    end
                    state_d = last_pix_s ? ST_FLUSH : ST_RUN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (!out_valid_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Single-entry output register; a new load wins over a same-cycle handshake.
    always_comb begin
        out_valid_d = out_valid_q;
        pixel_out_d = pixel_out_q;
        if (load_s) begin
            out_valid_d = 1'b1;
            pixel_out_d = load_val_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_DECIM;
            factor_q    <= FACTOR_2;
            width_q     <= '0;
            height_q    <= '0;
            col_q       <= '0;
            row_q       <= '0;
            hs_q        <= '0;
            out_valid_q <= 1'b0;
            pixel_out_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            factor_q    <= factor_d;
            width_q     <= width_d;
            height_q    <= height_d;
            col_q       <= col_d;
            row_q       <= row_d;
            hs_q        <= hs_d;
            out_valid_q <= out_valid_d;
            pixel_out_q <= pixel_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign pixel_out = pixel_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: doc/downscale_nx.md
# downscale_nx

Parametrised streaming image downscaler for the coprocessor datapath: consumes a raster-order pixel stream and produces a 2x or 4x reduced image by either decimation (top-left pixel of each block) or block averaging. Supersedes the fixed 2x decimator; sits between the frame read path and the output framebuffer writer. It uses valid/ready handshakes on both streams and supports runtime mode/factor selection per frame.

## Interface
- DATA_W, 8, pixel width in bits
- MAX_WIDTH, 320, maximum input line width in pixels (multiple of 4)
- DIM_W, 9, width of dimension inputs/counters (must hold MAX_WIDTH)

- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; latches config and begins a frame (ignored unless IDLE)
- mode  in  1  0 = decimation, 1 = block average
- factor_sel  in  1  0 = 2x, 1 = 4x
- img_width  in  DIM_W  input width in pixels
- img_height  in  DIM_W  input height in lines
- in_valid  in  1  pixel_in valid
- in_ready  out  1  block accepts pixel_in this cycle
- pixel_in  in  DATA_W  input pixel, raster order
- out_valid  out  1  pixel_out valid
- out_ready  in  1  downstream accepts pixel_out
- pixel_out  out  DATA_W  downscaled pixel, raster order
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last output pixel handshaked
- cfg_err  out  1  one-cycle pulse: start rejected for illegal config

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: on start, check config: width and height nonzero, both multiples of F (F = 2 or 4), img_width <= MAX_WIDTH. Illegal -> cfg_err pulse next cycle, stay IDLE. Legal -> latch mode/F/dims, clear counters, go RUN.
- RUN: accept pixel on in_valid && in_ready; track col (0..W-1), row (0..H-1).
- Decimation: on accept with row%F==0 && col%F==0, load pixel_in into output register.
- Average: horizontal sum hs accumulates F pixels of a group; at col%F==F-1, acc[col/F] = (row%F==0 ? 0 : acc[col/F]) + hs_total. At row%F==F-1 and col%F==F-1, output = (acc[col/F] + hs_total) >> (2·log2F), floor truncation. Accumulator width DATA_W+4; no overflow possible (all-max input yields max output).
- Output register single-entry; out_valid held until out_ready.
- After last input pixel (row H-1, col W-1) accepted -> FLUSH; FLUSH exits when out_valid low -> DONE; DONE asserts done one cycle -> IDLE.
- start during RUN/FLUSH/DONE ignored; config inputs sampled only at accepted start.
- Reset at any time: abort frame, all state cleared, no done.

## Timing
- Reset values: in_ready 0, out_valid 0, pixel_out 0, busy 0, done 0, cfg_err 0, state IDLE.
- in_ready = (state==RUN) && (!out_valid || out_ready) — combinational from out_ready.
- Output latency: out_valid rises the cycle after the triggering pixel is accepted.
- Simultaneous output handshake and new load in same cycle: new value replaces, out_valid stays high.
- Full throughput: one input pixel per cycle with out_ready held high.
- busy rises the cycle after the accepted start, falls with the done pulse's cycle end.
- Output count per frame: (W/F)·(H/F).

## Structure
- Package downscale_pkg: state encoding, MODE_DECIM/MODE_AVG, FACTOR_2/FACTOR_4 encodings, accumulator width constant.
- Sub-module downscale_acc_line: MAX_WIDTH/2 entries × (DATA_W+4) register array, combinational read, synchronous write; no reset of contents required (first-row write overrides).

## Test plan
- Decimation 2x, 4x4 ramp pixel=index 0..15 -> outputs 0, 2, 8, 10 then done.
- Average 2x, 4x2 image rows {10,20,30,40},{30,40,50,61} -> outputs 25, 45 (floor of 181/4).
- Average 4x, 8x4 all 255 -> two outputs of 255; all 0 -> two outputs of 0.
- Backpressure: out_ready low 5 cycles mid-frame -> in_ready low, pixel_out stable, no data lost; outputs match golden model.
- Config error: factor 4 with img_width=6 -> cfg_err one pulse, busy stays 0; start during RUN ignored.
- Reset asserted mid-frame -> outputs at reset values immediately; next legal frame produces correct outputs.
